// File: rtl/coupling_run_scheduler.sv
// Run sequencer for an array of clocked countdown coupling cells: programs weights,
// seeds the spins, runs the array for a bounded budget (or until stable), then captures.
module coupling_run_scheduler #(
  parameter int WIDTH   = 12,
  parameter int N_CELLS = 16,
  parameter int ADDR_W  = 4,
  parameter int CYC_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [ADDR_W-1:0]          cfg_addr,
  input  logic [WIDTH-1:0]           cfg_weight,
  input  logic                       start,
  input  logic [CYC_W-1:0]           run_budget,
  input  logic [CYC_W-1:0]           stable_cycles,
  input  logic [N_CELLS-1:0]         seed,
  output logic [N_CELLS*WIDTH-1:0]   cell_weight,
  output logic [N_CELLS-1:0]         cell_sin,
  output logic                       cell_en,
  input  logic [N_CELLS-1:0]         cell_dout,
  output logic                       busy,
  output logic                       done,
  output logic                       early_stop,
  output logic [N_CELLS-1:0]         spins,
  output logic [CYC_W-1:0]           cycles_used
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_ARM, S_RUN, S_SAMPLE, S_DONE
  } state_t;

  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(N_CELLS);

  state_t state, state_next;

  logic [WIDTH-1:0]   weights [N_CELLS];
  logic [CYC_W-1:0]   budget_q, stable_q;
  logic [CYC_W-1:0]   run_cnt, stab_cnt, run_next, stab_next;
  logic [N_CELLS-1:0] prev_dout;
  logic               run_hit, stab_hit;
  logic               cfg_fire, start_fire;

  assign cfg_ready  = (state == S_IDLE);
  assign cfg_fire   = cfg_valid & cfg_ready;
  assign start_fire = start & (state == S_IDLE);
  assign cell_en    = (state == S_ARM) || (state == S_RUN);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  for (genvar i = 0; i < N_CELLS; i++) begin : g_flat
    assign cell_weight[i*WIDTH +: WIDTH] = weights[i];
  end

  // NOTE: every signal written here gets a default first, so no path leaves a latch.
  always_comb begin
    run_next   = run_cnt + CYC_W'(1);
    stab_next  = (cell_dout != prev_dout) ? '0
               : ((&stab_cnt) ? stab_cnt : stab_cnt + CYC_W'(1));
    run_hit    = (run_next == budget_q);
    stab_hit   = (stable_q != '0) && (stab_next == stable_q);
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = (run_budget == '0) ? S_SAMPLE : S_SEED;
      S_SEED:   state_next = S_ARM;
      S_ARM:    state_next = S_RUN;
      S_RUN:    if (run_hit || stab_hit) state_next = S_SAMPLE;
      S_SAMPLE: state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the weight file is reset explicitly because cells must see all-zero weights after reset.
      for (int i = 0; i < N_CELLS; i++) weights[i] <= '0;
      budget_q    <= '0;
      stable_q    <= '0;
      run_cnt     <= '0;
      stab_cnt    <= '0;
      prev_dout   <= '0;
      cell_sin    <= '0;
      spins       <= '0;
      cycles_used <= '0;
      early_stop  <= 1'b0;
    end else begin
      prev_dout <= cell_dout;
      // Out-of-range addresses are handshaken but dropped.
      if (cfg_fire && ({1'b0, cfg_addr} < ADDR_LIMIT)) weights[cfg_addr] <= cfg_weight;
      case (state)
        S_IDLE: if (start_fire) begin
          budget_q   <= run_budget;
          stable_q   <= stable_cycles;
          run_cnt    <= '0;
          stab_cnt   <= '0;
          early_stop <= 1'b0;
          // A zero-budget run skips SEED, so the cells keep their previous seed.
          if (run_budget != '0) cell_sin <= seed;
        end
        S_SEED: begin
          run_cnt  <= '0;
          stab_cnt <= '0;
        end
        S_RUN: begin
          run_cnt  <= run_next;
          stab_cnt <= stab_next;
          if (run_hit || stab_hit) early_stop <= stab_hit;
        end
        S_SAMPLE: begin
          spins       <= cell_dout;
          cycles_used <= run_cnt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coupling_run_scheduler.sv
// Randomized bench for coupling_run_scheduler; expected run length, exit reason and
// captured spins come from a cycle-indexed model of the stimulus sequence.
module tb_coupling_run_scheduler;
  localparam int WIDTH   = 12;
  localparam int N_CELLS = 16;
  localparam int ADDR_W  = 4;
  localparam int CYC_W   = 16;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     cfg_valid = 1'b0;
  logic                     cfg_ready;
  logic [ADDR_W-1:0]        cfg_addr = '0;
  logic [WIDTH-1:0]         cfg_weight = '0;
  logic                     start = 1'b0;
  logic [CYC_W-1:0]         run_budget = '0;
  logic [CYC_W-1:0]         stable_cycles = '0;
  logic [N_CELLS-1:0]       seed = '0;
  logic [N_CELLS*WIDTH-1:0] cell_weight;
  logic [N_CELLS-1:0]       cell_sin;
  logic                     cell_en;
  logic [N_CELLS-1:0]       cell_dout = '0;
  logic                     busy, done, early_stop;
  logic [N_CELLS-1:0]       spins;
  logic [CYC_W-1:0]         cycles_used;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0]   exp_w [N_CELLS];
  logic [N_CELLS-1:0] seq [256];

  coupling_run_scheduler #(
    .WIDTH(WIDTH), .N_CELLS(N_CELLS), .ADDR_W(ADDR_W), .CYC_W(CYC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_weight(cfg_weight),
    .start(start), .run_budget(run_budget), .stable_cycles(stable_cycles), .seed(seed),
    .cell_weight(cell_weight), .cell_sin(cell_sin), .cell_en(cell_en), .cell_dout(cell_dout),
    .busy(busy), .done(done), .early_stop(early_stop), .spins(spins), .cycles_used(cycles_used)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N_CELLS*WIDTH-1:0] model_bus();
    logic [N_CELLS*WIDTH-1:0] b;
    for (int i = 0; i < N_CELLS; i++) b[i*WIDTH +: WIDTH] = exp_w[i];
    return b;
  endfunction

  // mode 0: random with occasional changes, 1: toggling every cycle, 2: constant from SEED on
  task automatic gen_seq(input int mode);
    logic [N_CELLS-1:0] base;
    base = N_CELLS'($urandom);
    for (int t = 0; t < 256; t++) begin
      case (mode)
        1:       seq[t] = (t % 2 == 1) ? ~base : base;
        2:       seq[t] = (t == 0) ? N_CELLS'($urandom) : base;
        default: seq[t] = (t == 0 || $urandom_range(0, 2) == 0) ? N_CELLS'($urandom) : seq[t-1];
      endcase
    end
  endtask

  // Run cycle i (1-based) sees seq[2+i]; it is compared to the value one cycle earlier
  // (the ARM cycle for i=1). Returns the number of run cycles used and the exit reason.
  function automatic void model_run(input int b, input int s, output int k, output bit early);
    int stab;
    stab = 0;
    k = b;
    early = 1'b0;
    for (int i = 1; i <= b; i++) begin
      if (seq[2+i] == seq[1+i]) stab++;
      else stab = 0;
      if (s != 0 && stab == s) begin
        k = i;
        early = 1'b1;
        break;
      end
    end
  endfunction

  task automatic run_check(input string name, input int b, input int s,
                           input logic [N_CELLS-1:0] sd, input bit poke,
                           input int cw_addr, input logic [WIDTH-1:0] cw_val);
    int k, sample_t, done_t, done_seen, done_cnt, en_cnt, ready_bad;
    bit early, in_run;
    logic [N_CELLS*WIDTH-1:0] exp_bus;
    model_run(b, s, k, early);
    sample_t  = (b == 0) ? 1 : 3 + k;
    done_t    = sample_t + 1;
    done_seen = -1;
    done_cnt  = 0;
    en_cnt    = 0;
    ready_bad = 0;
    run_budget    = CYC_W'(b);
    stable_cycles = CYC_W'(s);
    seed          = sd;
    if (cw_addr >= 0) exp_w[cw_addr] = cw_val;
    for (int t = 0; t <= done_t + 3; t++) begin
      in_run    = (b != 0) && (t >= 3) && (t < 3 + k);
      start     = (t == 0) || (poke && in_run);
      cfg_valid = (t == 0 && cw_addr >= 0) || (poke && in_run);
      if (t == 0 && cw_addr >= 0) begin
        cfg_addr   = ADDR_W'(cw_addr);
        cfg_weight = cw_val;
      end else if (poke && in_run) begin
        cfg_addr   = ADDR_W'($urandom);
        cfg_weight = WIDTH'($urandom);
      end
      cell_dout = seq[t];
      if (done) begin
        done_cnt++;
        if (done_seen < 0) done_seen = t;
      end
      if (cell_en) en_cnt++;
      if (poke && in_run && cfg_ready) ready_bad++;
      if (t == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        if (b != 0) begin
          checks++;
          if (cell_sin !== sd) begin
            errors++;
            $display("FAIL %s cell_sin_seed: got %h want %h", name, cell_sin, sd);
          end
        end
      end
      if (t == done_t) begin
        checks++;
        if (early_stop !== early) begin
          errors++;
          $display("FAIL %s early_stop: got %b want %b", name, early_stop, early);
        end
        checks++;
        if (cycles_used !== CYC_W'(k)) begin
          errors++;
          $display("FAIL %s cycles_used: got %0d want %0d", name, cycles_used, k);
        end
        checks++;
        if (spins !== seq[sample_t]) begin
          errors++;
          $display("FAIL %s spins: got %h want %h", name, spins, seq[sample_t]);
        end
      end
      if (t == done_t + 1) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL %s busy_after_done: got %b want 0", name, busy);
        end
      end
      step();
    end
    start     = 1'b0;
    cfg_valid = 1'b0;
    checks++;
    if (done_seen != done_t || done_cnt != 1) begin
      errors++;
      $display("FAIL %s done_timing: got cycle %0d (pulses %0d) want cycle %0d (pulses 1)",
               name, done_seen, done_cnt, done_t);
    end
    checks++;
    if (en_cnt != ((b == 0) ? 0 : k + 1)) begin
      errors++;
      $display("FAIL %s cell_en_cycles: got %0d want %0d", name, en_cnt, (b == 0) ? 0 : k + 1);
    end
    if (poke) begin
      checks++;
      if (ready_bad != 0) begin
        errors++;
        $display("FAIL %s cfg_ready_in_run: high on %0d run cycles want 0", name, ready_bad);
      end
    end
    exp_bus = model_bus();
    checks++;
    if (cell_weight !== exp_bus) begin
      errors++;
      $display("FAIL %s weights_after_run: got %h want %h", name, cell_weight, exp_bus);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step();
    step();
    for (int i = 0; i < N_CELLS; i++) exp_w[i] = '0;
    checks++;
    if ({cfg_ready, busy, done, cell_en, early_stop} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got ready/busy/done/en/early=%b want 10000",
               {cfg_ready, busy, done, cell_en, early_stop});
    end
    checks++;
    if (cell_weight !== '0 || cell_sin !== '0 || spins !== '0 || cycles_used !== '0) begin
      errors++;
      $display("FAIL reset_data: got weight=%h sin=%h spins=%h cycles=%0d want all 0",
               cell_weight, cell_sin, spins, cycles_used);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic cfg_write(input string name, input int addr, input logic [WIDTH-1:0] w);
    logic [N_CELLS*WIDTH-1:0] exp_bus;
    cfg_valid  = 1'b1;
    cfg_addr   = ADDR_W'(addr);
    cfg_weight = w;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s cfg_ready_idle: got %b want 1", name, cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    exp_w[addr] = w;
    exp_bus = model_bus();
    checks++;
    if (cell_weight !== exp_bus) begin
      errors++;
      $display("FAIL %s cell_weight: got %h want %h", name, cell_weight, exp_bus);
    end
  endtask

  task automatic test_cfg_write;
    cfg_write("cfg_cell0", 0, 12'd5);
    cfg_write("cfg_cell1_zero", 1, 12'd0);
    cfg_write("cfg_cell15_max", 15, 12'hFFF);
    for (int i = 0; i < 4; i++) cfg_write("cfg_random", $urandom_range(0, N_CELLS - 1), WIDTH'($urandom));
  endtask

  task automatic test_budget_run;
    gen_seq(1);
    run_check("budget_run", 10, 0, 16'hA5A5, 1'b0, -1, '0);
    step();
  endtask

  task automatic test_early_stop;
    gen_seq(2);
    run_check("early_stop", 100, 4, N_CELLS'($urandom), 1'b0, -1, '0);
    step();
  endtask

  task automatic test_zero_budget;
    gen_seq(0);
    run_check("zero_budget", 0, 3, N_CELLS'($urandom), 1'b0, -1, '0);
    step();
  endtask

  task automatic test_run_ignores_host;
    gen_seq(1);
    run_check("run_ignores_host", 12, 0, N_CELLS'($urandom), 1'b1, -1, '0);
    step();
  endtask

  task automatic test_back_to_back;
    gen_seq(0);
    run_check("start_with_write", $urandom_range(1, 30), $urandom_range(0, 5),
              N_CELLS'($urandom), 1'b0, $urandom_range(0, N_CELLS - 1), WIDTH'($urandom));
    for (int r = 0; r < 6; r++) begin
      gen_seq($urandom_range(0, 2));
      run_check("random_run", $urandom_range(1, 40), $urandom_range(0, 6),
                N_CELLS'($urandom), r[0], -1, '0);
    end
  endtask

  task automatic test_reset_mid_run;
    int done_cnt;
    gen_seq(1);
    run_budget    = CYC_W'(20);
    stable_cycles = '0;
    seed          = N_CELLS'($urandom);
    for (int t = 0; t < 6; t++) begin
      start     = (t == 0);
      cell_dout = seq[t];
      rst_n     = (t != 5);
      step();
    end
    rst_n = 1'b1;
    for (int i = 0; i < N_CELLS; i++) exp_w[i] = '0;
    checks++;
    if ({cfg_ready, busy, done, cell_en} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_mid_run_flags: got ready/busy/done/en=%b want 1000",
               {cfg_ready, busy, done, cell_en});
    end
    checks++;
    if (cell_weight !== '0) begin
      errors++;
      $display("FAIL reset_mid_run_weights: got %h want 0", cell_weight);
    end
    done_cnt = 0;
    for (int t = 0; t < 30; t++) begin
      if (done || busy) done_cnt++;
      step();
    end
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL reset_mid_run_no_done: got %0d done/busy cycles want 0", done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_cfg_write();
    test_budget_run();
    test_early_stop();
    test_zero_budget();
    test_run_ignores_host();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coupling_run_scheduler.md
Name: coupling_run_scheduler

Overview:
- Sequences one annealing run of an array of N_CELLS clocked countdown coupling cells: programs the per-cell weight registers, seeds the spin network, enables the cells for a bounded cycle budget, then freezes and captures the spin state.
- Ends a run early when the spin vector has been stable for a programmable number of cycles.
- Sits between the host configuration bus and the coupling cell array.

Parameters:
- WIDTH, 12, weight/countdown width per coupling cell
- N_CELLS, 16, number of coupling cells driven
- ADDR_W, 4, cell address width (2^ADDR_W >= N_CELLS)
- CYC_W, 16, width of the run-budget and stability counters

Ports:
- clk  in  1  system clock (all cells share it)
- rst_n  in  1  synchronous active-low reset
- cfg_valid  in  1  weight write request
- cfg_ready  out  1  weight write accepted when high with cfg_valid
- cfg_addr  in  ADDR_W  target cell index
- cfg_weight  in  WIDTH  weight value to store
- start  in  1  one-cycle pulse; begins a run
- run_budget  in  CYC_W  max RUN cycles, sampled on start
- stable_cycles  in  CYC_W  early-stop threshold, sampled on start; 0 disables early stop
- seed  in  N_CELLS  initial spin vector, sampled on start
- cell_weight  out  N_CELLS*WIDTH  flattened weight bus to cells; cell i at [i*WIDTH +: WIDTH]
- cell_sin  out  N_CELLS  spin seed driven to cells
- cell_en  out  1  cell enable; cells count only while high
- cell_dout  in  N_CELLS  live spin outputs from cells
- busy  out  1  high from start acceptance until DONE exits
- done  out  1  one-cycle pulse on run completion
- early_stop  out  1  valid with done; 1 = stability exit, 0 = budget exhausted
- spins  out  N_CELLS  captured spin vector, held until the next capture
- cycles_used  out  CYC_W  RUN cycles consumed, valid with done

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; all weight registers 0; cell_weight 0; cell_sin 0; cell_en 0; busy 0; done 0; early_stop 0; spins 0; cycles_used 0; cfg_ready 1. Reset mid-run aborts immediately with no done pulse.
- cfg_ready = 1 only in IDLE.
  - Write occurs on cycle with cfg_valid & cfg_ready; the weight is visible on cell_weight the next cycle.
  - cfg_addr >= N_CELLS: accepted, write discarded.
- Weight 0 is legal and is passed through unchanged.
- States:
  - IDLE:
    - start=1 latches run_budget, stable_cycles and seed, and sets busy=1 next cycle.
    - If start and a cfg write coincide, the write commits first, then the run starts.
    - start with run_budget=0: go straight to SAMPLE.
  - SEED (1 cycle): cell_sin=seed, cell_en=0, counters cleared.
  - ARM (1 cycle): cell_sin held, cell_en=1.
  - RUN:
    - cell_en=1; run counter increments each cycle.
    - Stability counter resets to 0 whenever cell_dout differs from its previous-cycle value, else increments (saturating).
    - Exit to SAMPLE when run counter == budget (early_stop=0), or stable_cycles!=0 and stability counter == stable_cycles (early_stop=1).
    - If both conditions hold in the same cycle, early_stop=1.
    - start is ignored in RUN.
  - SAMPLE (1 cycle): cell_en=0; spins <= cell_dout; cycles_used <= run counter.
  - DONE (1 cycle): done=1; busy drops to 0 next cycle; return to IDLE.
- Latency with run_budget=B and no early stop:
  - start at cycle 0.
  - SEED at cycle 1, ARM at 2, RUN over cycles 3..3+B-1.
  - SAMPLE at cycle 3+B.
  - done at cycle 4+B.
- Counters are CYC_W wide and never wrap: run_budget max 2^CYC_W-1, and the stability counter saturates.
- cell_sin holds its seed value until the next SEED.

Test Plan:
- Write weights 5,0,4095 to cells 0,1,15 (cell 1 written with weight 0) -> cell_weight slices equal 5,0,0xFFF one cycle after each handshake; other slices remain 0.
- start with run_budget=10, stable_cycles=0, seed=0xA5A5, and cell_dout toggling every cycle -> done exactly 14 cycles after start; early_stop=0; cycles_used=10; spins equal cell_dout at SAMPLE.
- run_budget=100, stable_cycles=4, cell_dout constant from the first RUN cycle -> done with early_stop=1 and cycles_used=4.
- start with run_budget=0 -> cell_en never asserted; done 2 cycles after start; cycles_used=0.
- During RUN, assert cfg_valid and start -> cfg_ready=0, weights unchanged, run completes normally.
- Drive rst_n low in RUN cycle 3 -> next cycle: state IDLE, cell_en=0, busy=0, all weights 0, no done pulse.
